// File: rtl/instr_ram_banked_wrap.sv
// Banked instruction RAM. After reset it clears every word, then serves one request per cycle.
// Define INSTR_RAM_PARITY_EN to store and check one even-parity bit per byte.
module instr_ram_banked_wrap #(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BANKS  = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE)
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    en_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    bypass_en_i,
  output logic                    gnt_o,
  output logic                    init_busy_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rvalid_o,
  output logic                    err_o
);

  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS   = $clog2(BYTES);
  localparam int unsigned NUM_WORDS  = RAM_SIZE / BYTES;
  localparam int unsigned BANK_WORDS = NUM_WORDS / NUM_BANKS;
  localparam int unsigned IDX_BITS   = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  localparam int unsigned BANK_BITS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned WORD_AW    = ADDR_WIDTH - OFF_BITS;

  typedef enum logic {StInit, StReady} state_e;

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   init_cnt_q, init_cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  logic [WORD_AW-1:0]    word_addr;
  logic [IDX_BITS-1:0]   idx;
  logic [BANK_BITS-1:0]  bank_sel;
  logic                  arr_we;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] rd_word;

  assign word_addr = addr_i[ADDR_WIDTH-1:OFF_BITS];
  assign idx       = word_addr[IDX_BITS-1:0];

  if (NUM_BANKS > 1) begin : g_bank_sel
    assign bank_sel = word_addr[IDX_BITS +: BANK_BITS];
  end else begin : g_one_bank
    logic unused_word_addr;
    assign unused_word_addr = ^word_addr;
    assign bank_sel = '0;
  end

  if (OFF_BITS > 0) begin : g_unused_off
    logic unused_addr_off;
    assign unused_addr_off = ^addr_i[OFF_BITS-1:0];
  end

  assign init_busy_o = (state_q == StInit);
  assign gnt_o       = en_i & ~init_busy_o;
  assign arr_we      = gnt_o & we_i & ~bypass_en_i;
  assign rd_word     = bank_rdata[bank_sel];

`ifdef INSTR_RAM_PARITY_EN
  logic [BYTES-1:0] bank_rpar [NUM_BANKS];
  logic [BYTES-1:0] wpar, rpar_calc, rd_par;
  logic             err_q, err_d;

  always_comb begin
    wpar      = '0;
    rpar_calc = '0;
    for (int i = 0; i < BYTES; i++) begin
      wpar[i]      = ^wdata_i[8*i +: 8];
      rpar_calc[i] = ^rd_word[8*i +: 8];
    end
  end

  assign rd_par = bank_rpar[bank_sel];
  assign err_d  = gnt_o & ~we_i & ~bypass_en_i & (|(rd_par ^ rpar_calc));

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
    logic                  bank_we;

    assign bank_we = arr_we && (bank_sel == BANK_BITS'(b));

    // Clearing writes the same index in every bank at once.
    always_ff @(posedge clk) begin
      if (init_busy_o) begin
        mem[init_cnt_q] <= '0;
      end else if (bank_we) begin
        for (int i = 0; i < BYTES; i++) begin
          if (be_i[i]) mem[idx][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end

    assign bank_rdata[b] = mem[idx];

`ifdef INSTR_RAM_PARITY_EN
    logic [BYTES-1:0] par_mem [BANK_WORDS];

    // Parity of an all-zero byte is zero, so clearing stores zero parity.
    always_ff @(posedge clk) begin
      if (init_busy_o) begin
        par_mem[init_cnt_q] <= '0;
      end else if (bank_we) begin
        for (int i = 0; i < BYTES; i++) begin
          if (be_i[i]) par_mem[idx][i] <= wpar[i];
        end
      end
    end

    assign bank_rpar[b] = par_mem[idx];
`endif
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_BITS'(BANK_WORDS - 1)) begin
          state_d    = StReady;
          init_cnt_d = '0;
        end
      end
      StReady: ;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = gnt_o & (bypass_en_i | ~we_i);
    if (rvalid_d) rdata_d = bypass_en_i ? wdata_i : rd_word;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_instr_ram_banked_wrap.sv
// Directed self-checking bench for instr_ram_banked_wrap (4 KiB, 32-bit words, 2 banks).
module tb_instr_ram_banked_wrap;

  localparam int unsigned RS = 4096;
  localparam int unsigned DW = 32;
  localparam int unsigned NB = 2;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          en_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic          we_i = 1'b0;
  logic [3:0]    be_i = '0;
  logic [31:0]   wdata_i = '0;
  logic          bypass_en_i = 1'b0;
  logic          gnt_o, init_busy_o, rvalid_o, err_o;
  logic [31:0]   rdata_o;

  int n_cmp = 0;
  int n_err = 0;

  instr_ram_banked_wrap #(
    .RAM_SIZE  (RS),
    .DATA_WIDTH(DW),
    .NUM_BANKS (NB),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .be_i       (be_i),
    .wdata_i    (wdata_i),
    .bypass_en_i(bypass_en_i),
    .gnt_o      (gnt_o),
    .init_busy_o(init_busy_o),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic we, input logic byp, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    en_i        = en;
    we_i        = we;
    bypass_en_i = byp;
    addr_i      = a;
    be_i        = be;
    wdata_i     = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
  endtask

  task automatic test_reset_and_init();
    int cycles;
    rstn_i = 1'b0;
    idle();
    #2;
    n_cmp++; if (init_busy_o !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b want 1", init_busy_o); end
    n_cmp++; if (rvalid_o !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", rvalid_o); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err_o); end
    @(negedge clk);
    rstn_i = 1'b1;
    // Requests during clearing must be ignored.
    drive(1'b1, 1'b1, 1'b0, 12'h7FC, 4'hF, 32'hFFFF_FFFF);
    #1;
    n_cmp++; if (gnt_o !== 1'b0) begin n_err++; $display("FAIL init_gnt got %b want 0", gnt_o); end
    cycles = 0;
    while (init_busy_o === 1'b1 && cycles < 2000) begin
      tick();
      cycles++;
      if (cycles == 4) drive(1'b1, 1'b0, 1'b0, 12'h7FC, 4'hF, 32'h0);
      if (cycles == 8) idle();
      if (cycles <= 8) begin
        n_cmp++;
        if (rvalid_o !== 1'b0 || gnt_o !== 1'b0) begin
          n_err++; $display("FAIL init_ignore cyc %0d got rvalid %b gnt %b want 0 0",
                            cycles, rvalid_o, gnt_o);
        end
      end
    end
    n_cmp++; if (cycles != 512) begin n_err++; $display("FAIL init_len got %0d want 512", cycles); end
    n_cmp++; if (init_busy_o !== 1'b0) begin n_err++; $display("FAIL ready_busy got %b want 0", init_busy_o); end
    drive(1'b1, 1'b0, 1'b0, 12'h7FC, 4'hF, 32'h0);
    tick();
    idle();
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin
      n_err++; $display("FAIL read_7fc got %b/%h want 1/00000000", rvalid_o, rdata_o); end
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 1'b1, 1'b0, 12'h004, 4'hF, 32'hDEAD_BEEF);
    #1;
    n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL wr_gnt got %b want 1", gnt_o); end
    tick();
    n_cmp++; if (rvalid_o !== 1'b0) begin n_err++; $display("FAIL wr_rvalid got %b want 0", rvalid_o); end
    drive(1'b1, 1'b1, 1'b0, 12'h004, 4'h1, 32'h0000_00AA);
    tick();
    drive(1'b1, 1'b0, 1'b0, 12'h004, 4'h0, 32'h0);
    tick();
    idle();
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEAA) begin
      n_err++; $display("FAIL be_read got %b/%h want 1/deadbeaa", rvalid_o, rdata_o); end
    tick();
    n_cmp++; if (rvalid_o !== 1'b0 || rdata_o !== 32'hDEAD_BEAA) begin
      n_err++; $display("FAIL hold got %b/%h want 0/deadbeaa", rvalid_o, rdata_o); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b1, 1'b1, 12'h010, 4'hF, 32'h1234_5678);
    tick();
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h1234_5678) begin
      n_err++; $display("FAIL byp_wr got %b/%h want 1/12345678", rvalid_o, rdata_o); end
    drive(1'b1, 1'b0, 1'b1, 12'h010, 4'h0, 32'hCAFE_F00D);
    tick();
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL byp_rd got %b/%h want 1/cafef00d", rvalid_o, rdata_o); end
    drive(1'b1, 1'b0, 1'b0, 12'h010, 4'h0, 32'h0);
    tick();
    idle();
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin
      n_err++; $display("FAIL byp_nowrite got %b/%h want 1/00000000", rvalid_o, rdata_o); end
  endtask

  task automatic test_banks();
    drive(1'b1, 1'b1, 1'b0, 12'h000, 4'hF, 32'h1111_1111);
    tick();
    drive(1'b1, 1'b1, 1'b0, 12'h800, 4'hF, 32'h2222_2222);
    tick();
    drive(1'b1, 1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
    tick();
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h1111_1111) begin
      n_err++; $display("FAIL bank0 got %b/%h want 1/11111111", rvalid_o, rdata_o); end
    drive(1'b1, 1'b0, 1'b0, 12'h800, 4'h0, 32'h0);
    tick();
    idle();
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h2222_2222) begin
      n_err++; $display("FAIL bank1 got %b/%h want 1/22222222", rvalid_o, rdata_o); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [4];
    logic [31:0]   datas [4];
    addrs = '{12'h100, 12'h104, 12'h900, 12'h904};
    datas = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003, 32'hF0F0_0004};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, addrs[i], 4'hF, datas[i]);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, addrs[i], 4'h0, 32'h0);
      tick();
      n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== datas[i]) begin
        n_err++; $display("FAIL b2b_rd%0d got %b/%h want 1/%h", i, rvalid_o, rdata_o, datas[i]); end
    end
    drive(1'b1, 1'b1, 1'b0, 12'h104, 4'hF, 32'h7777_8888);
    tick();
    drive(1'b1, 1'b0, 1'b0, 12'h104, 4'h0, 32'h0);
    tick();
    idle();
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h7777_8888) begin
      n_err++; $display("FAIL raw got %b/%h want 1/77778888", rvalid_o, rdata_o); end
  endtask

  task automatic test_parity();
    drive(1'b1, 1'b1, 1'b0, 12'h020, 4'hF, 32'hA5C3_0F01);
    tick();
    idle();
`ifdef INSTR_RAM_PARITY_EN
    dut.g_bank[0].par_mem[8][0] = ~dut.g_bank[0].par_mem[8][0];
`endif
    drive(1'b1, 1'b0, 1'b0, 12'h020, 4'h0, 32'h0);
    tick();
    idle();
`ifdef INSTR_RAM_PARITY_EN
    n_cmp++; if (rvalid_o !== 1'b1 || err_o !== 1'b1) begin
      n_err++; $display("FAIL par_err got %b/%b want 1/1", rvalid_o, err_o); end
`else
    n_cmp++; if (rvalid_o !== 1'b1 || err_o !== 1'b0) begin
      n_err++; $display("FAIL par_none got %b/%b want 1/0", rvalid_o, err_o); end
`endif
    drive(1'b1, 1'b0, 1'b0, 12'h004, 4'h0, 32'h0);
    tick();
    idle();
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL par_clean got %b want 0", err_o); end
  endtask

  task automatic test_reset_restart();
    int cycles;
    @(posedge clk);
    #2;
    rstn_i = 1'b0;
    #1;
    n_cmp++; if (init_busy_o !== 1'b1 || rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
      n_err++; $display("FAIL async_rst got %b/%b/%h want 1/0/00000000",
                        init_busy_o, rvalid_o, rdata_o); end
    @(negedge clk);
    rstn_i = 1'b1;
    cycles = 0;
    while (init_busy_o === 1'b1 && cycles < 2000) begin
      tick();
      cycles++;
    end
    n_cmp++; if (cycles != 512) begin n_err++; $display("FAIL reinit_len got %0d want 512", cycles); end
    drive(1'b1, 1'b0, 1'b0, 12'h004, 4'h0, 32'h0);
    tick();
    idle();
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin
      n_err++; $display("FAIL reinit_clr got %b/%h want 1/00000000", rvalid_o, rdata_o); end
  endtask

  initial begin
    test_reset_and_init();
    test_byte_enable();
    test_bypass();
    test_banks();
    test_back_to_back();
    test_parity();
    test_reset_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
